// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero short-circuits to DONE with quot=all ones and rem=dividend.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  // The partial remainder always stays below D, so WIDTH bits hold it;
  // only the trial value T needs the extra bit.
  assign w_t      = {r_r, r_q[WIDTH-1]};
  assign w_ge     = (w_t >= {1'b0, r_d});
  assign w_r_next = w_ge ? WIDTH'(w_t - {1'b0, r_d}) : w_t[WIDTH-1:0];
  assign w_q_next = {r_q[WIDTH-2:0], w_ge};

  assign busy        = r_busy;
  assign done        = r_done;
  assign quot        = r_quot;
  assign rem         = r_rem;
  assign div_by_zero = r_dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_q   <= dividend;
            r_d   <= divisor;
            r_r   <= '0;
            r_cnt <= CW'(WIDTH);
            if (divisor != '0) begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_rem   <= dividend;
              r_dbz   <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - CW'(1);
          // Last iteration: publish the freshly computed bits directly.
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_next;
            r_rem   <= w_r_next;
            r_dbz   <= 1'b0;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
